// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite types: response codes, slave FSM states, strobe width.
// Imported by axilite_slave_regs, axilite_regfile and axilite_master.
package axilite_pkg;

    localparam int AXI_STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axilite_regfile.sv
// NUM_REGS x 32-bit register file with byte-enabled write port.
// Ports: clk, rst_n, we/widx/wdata/wstrb (write), ridx->rdata (comb read), regs_out (flat).
module axilite_regfile
    import axilite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [31:0]             wdata,
    input  logic [AXI_STRB_W-1:0]   wstrb,
    input  logic [IDX_W-1:0]        ridx,
    output logic [31:0]             rdata,
    output logic [NUM_REGS*32-1:0]  regs_out
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read sees the pre-write value when a write lands on the same edge.
    assign rdata = mem[ridx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[32*g +: 32] = mem[g];
    end

endmodule

// File: rtl/axilite_slave_regs.sv
// AXI4-Lite slave terminating AW/W/B/AR/R in front of a register file.
// Ports: ACLK, ARESETn, AXI-Lite slave channels, REGS_OUT (flat register contents).
module axilite_slave_regs
    import axilite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        WVALID,
    output logic                        WREADY,
    input  logic [31:0]                 WDATA,
    input  logic [3:0]                  WSTRB,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [1:0]                  BRESP,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [31:0]                 RDATA,
    output logic [1:0]                  RRESP,
    output logic [NUM_REGS*32-1:0]      REGS_OUT
);

    localparam int IDX_W = $clog2(NUM_REGS);

    if (AXI_DATA_WIDTH != 32) begin : g_bad_dw
        $error("axilite_slave_regs: AXI_DATA_WIDTH must be 32");
    end
    if (NUM_REGS < 2 || NUM_REGS > 64 || (1 << IDX_W) != NUM_REGS) begin : g_bad_nr
        $error("axilite_slave_regs: NUM_REGS must be a power of two in 2..64");
    end

    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    // ---------------- write path ----------------
    wr_state_t                 wr_state, wr_next;
    logic                      aw_got, w_got, aw_got_d, w_got_d;
    logic                      aw_ready_d, w_ready_d, b_valid_d;
    logic [1:0]                b_resp_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
    logic [31:0]               w_data_q, wr_data;
    logic [3:0]                w_strb_q, wr_strb;
    logic                      aw_hs, w_hs, b_hs, commit, wr_ok;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    // A channel handshaking this cycle bypasses its holding register.
    assign wr_addr = aw_hs ? AWADDR : aw_addr_q;
    assign wr_data = w_hs ? WDATA : w_data_q;
    assign wr_strb = w_hs ? WSTRB : w_strb_q;
    assign commit  = (wr_state == WR_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    assign wr_ok   = in_range(wr_addr);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state  <= WR_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            wr_state <= wr_next;
            aw_got   <= aw_got_d;
            w_got    <= w_got_d;
            AWREADY  <= aw_ready_d;
            WREADY   <= w_ready_d;
            BVALID   <= b_valid_d;
            BRESP    <= b_resp_d;
            if (aw_hs) aw_addr_q <= AWADDR;
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (commit) wr_next = WR_RESP;
            WR_RESP: if (b_hs) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        aw_got_d  = aw_got;
        w_got_d   = w_got;
        b_valid_d = BVALID;
        b_resp_d  = BRESP;
        if (commit) begin
            aw_got_d  = 1'b0;
            w_got_d   = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? OKAY : SLVERR;
        end else begin
            if (aw_hs) aw_got_d = 1'b1;
            if (w_hs) w_got_d = 1'b1;
            if (b_hs) b_valid_d = 1'b0;
        end
        aw_ready_d = (wr_next == WR_IDLE) && !aw_got_d;
        w_ready_d  = (wr_next == WR_IDLE) && !w_got_d;
    end

    // ---------------- read path ----------------
    rd_state_t   rd_state, rd_next;
    logic        ar_hs, r_hs, rd_ok;
    logic        ar_ready_d, r_valid_d;
    logic [31:0] r_data_d, rf_rdata;
    logic [1:0]  r_resp_d;

    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;
    assign rd_ok = in_range(ARADDR);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= OKAY;
        end else begin
            rd_state <= rd_next;
            ARREADY  <= ar_ready_d;
            RVALID   <= r_valid_d;
            RDATA    <= r_data_d;
            RRESP    <= r_resp_d;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (r_hs) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        r_valid_d = RVALID;
        r_data_d  = RDATA;
        r_resp_d  = RRESP;
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_ok ? rf_rdata : '0;
            r_resp_d  = rd_ok ? OKAY : SLVERR;
        end else if (r_hs) begin
            r_valid_d = 1'b0;
        end
        ar_ready_d = (rd_next == RD_IDLE);
    end

    // ---------------- storage ----------------
    axilite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .we       (commit && wr_ok),
        .widx     (wr_addr[IDX_W+1:2]),
        .wdata    (wr_data),
        .wstrb    (wr_strb),
        .ridx     (ARADDR[IDX_W+1:2]),
        .rdata    (rf_rdata),
        .regs_out (REGS_OUT)
    );

endmodule

// File: tb/tb_axilite_slave_regs.sv
// Scoreboard bench for axilite_slave_regs (NUM_REGS=8).
// Stimulus pushes expected B/R responses; a monitor pops them on handshakes.
module tb_axilite_slave_regs;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        AWVALID = 1'b0, AWREADY;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        WVALID = 1'b0, WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID, BREADY = 1'b1;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0, ARREADY;
    logic [31:0] ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        RVALID, RREADY = 1'b1;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [255:0] REGS_OUT;

    axilite_slave_regs #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .NUM_REGS       (8)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .REGS_OUT(REGS_OUT)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;
    int b_seen   = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. just before the handshake edge.
    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            b_seen++;
            if (bq.size() == 0) begin
                check("b_unexpected", 256'(BRESP), 256'h1_0000);
            end else begin
                check("bresp", 256'(BRESP), 256'(bq.pop_front()));
            end
        end
        if (ARESETn && RVALID && RREADY) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 256'({RDATA, RRESP}), 256'h1_0000_0000_0000);
            end else begin
                check("rdata_rresp", 256'({RDATA, RRESP}), 256'(rq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit push, input logic [1:0] r);
        bit da = 0, dw = 0;
        int n = 0;
        if (push) bq.push_back(r);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1;
        while (!(da && dw) && n < 50) begin
            @(negedge ACLK);
            if (AWVALID && AWREADY) da = 1;
            if (WVALID && WREADY) dw = 1;
            tick();
            if (da) AWVALID = 1'b0;
            if (dw) WVALID = 1'b0;
            n++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check("write_hs_timeout", 256'(da && dw), 256'(1));
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        bit done = 0;
        int n = 0;
        rq.push_back({d, r});
        ARADDR = a;
        ARVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge ACLK);
            if (ARREADY) done = 1;
            tick();
            n++;
        end
        ARVALID = 1'b0;
        check("read_hs_timeout", 256'(done), 256'(1));
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            tick();
            ok = !BVALID && !RVALID && AWREADY && WREADY && ARREADY;
        end
        check("idle_timeout", 256'(ok), 256'(1));
    endtask

    initial begin
        logic [255:0] saved;
        int b0;

        // Reset
        repeat (2) tick();
        check("rst_ready", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
        check("rst_valid", 256'({BVALID, RVALID, BRESP, RRESP}), 256'(0));
        check("rst_regs", REGS_OUT, 256'(0));
        ARESETn = 1'b1;
        tick();
        check("ready_after_rst", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));

        // Simultaneous AW+W
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 1, 2'b00);
        check("simul_bvalid", 256'(BVALID), 256'(1));
        check("simul_reg1", 256'(REGS_OUT[63:32]), 256'(32'hDEADBEEF));
        wait_idle();

        // W three cycles before AW, byte lanes
        axi_write(32'h08, 32'hAAAAAAAA, 4'hF, 1, 2'b00);
        wait_idle();
        b0 = b_seen;
        WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("w_first_wready", 256'(WREADY), 256'(0));
        check("w_first_bvalid0", 256'(BVALID), 256'(0));
        tick();
        check("w_first_bvalid1", 256'(BVALID), 256'(0));
        tick();
        check("w_first_bvalid2", 256'(BVALID), 256'(0));
        check("w_first_awready", 256'(AWREADY), 256'(1));
        bq.push_back(2'b00);
        AWADDR = 32'h08; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("w_first_bvalid_aw", 256'(BVALID), 256'(1));
        check("w_first_reg2", 256'(REGS_OUT[95:64]), 256'(32'hAA22AA44));
        wait_idle();
        repeat (3) tick();
        check("w_first_one_b", 256'(b_seen - b0), 256'(1));

        // Out of range
        saved = REGS_OUT;
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 1, 2'b10);
        wait_idle();
        check("oor_no_change", REGS_OUT, saved);
        axi_read(32'h20, 32'h0, 2'b10);
        wait_idle();

        // Read backpressure
        RREADY = 1'b0;
        axi_read(32'h04, 32'hDEADBEEF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 256'({RVALID, ARREADY, RDATA, RRESP}),
                  256'({1'b1, 1'b0, 32'hDEADBEEF, 2'b00}));
            if (i < 4) tick();
        end
        RREADY = 1'b1;
        wait_idle();

        // Same-register collision
        axi_write(32'h0C, 32'h1, 4'hF, 1, 2'b00);
        wait_idle();
        bq.push_back(2'b00);
        rq.push_back({32'h1, 2'b00});
        AWADDR = 32'h0C; WDATA = 32'h5; WSTRB = 4'hF; ARADDR = 32'h0C;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("coll_reg3", 256'(REGS_OUT[127:96]), 256'(32'h5));
        wait_idle();

        // Reset while B outstanding
        BREADY = 1'b0;
        axi_write(32'h00, 32'h12345678, 4'hF, 0, 2'b00);
        check("mid_bvalid_pre", 256'(BVALID), 256'(1));
        #3;
        ARESETn = 1'b0;
        #1;
        check("mid_bvalid_async", 256'(BVALID), 256'(0));
        check("mid_regs_clear", REGS_OUT, 256'(0));
        tick();
        check("mid_ready_rst", 256'({AWREADY, WREADY, ARREADY}), 256'(0));
        BREADY = 1'b1;
        ARESETn = 1'b1;
        tick();
        check("mid_ready_rel", 256'({AWREADY, WREADY, ARREADY}), 256'(3'b111));
        repeat (3) tick();
        check("mid_no_resp", 256'({BVALID, RVALID}), 256'(0));

        check("bq_drained", 256'(bq.size()), 256'(0));
        check("rq_drained", 256'(rq.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
